// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: opcode classes, ALU operand
// selects, sequencer states and the registered control word.
package ctrl_pkg;

   localparam logic       CLS_ALU   = 1'b1;
   localparam logic [1:0] CLS_CTRL  = 2'b00;
   localparam logic [2:0] CLS_MEM   = 3'b010;
   localparam logic [2:0] CLS_SPR   = 3'b011;
   localparam logic [3:0] SPR_STORE = 4'b1111;

   localparam logic [1:0] SRC_RT    = 2'b00;
   localparam logic [1:0] SRC_IMM   = 2'b01;
   localparam logic [1:0] SRC_SHAMT = 2'b10;
   localparam logic [1:0] SRC_SPR   = 2'b11;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   typedef struct packed {
      logic       call;
      logic       ret;
      logic       branch;
      logic       mem_to_reg;
      logic       mem_src;
      logic       sign_ext_sel;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       oam_write;
      logic [1:0] alu_src;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction handshake and registered control-word bundle between
// the fetch side (master) and the control sequencer (slave).
interface control_sequencer_if #(
   parameter int CNT_W = 4
);

   logic             instr_valid;
   logic [5:0]       opcode;
   logic             stall;
   logic             flush;
   logic             instr_ready;
   logic             call;
   logic             ret;
   logic             branch;
   logic             mem_to_reg;
   logic             mem_src;
   logic             sign_ext_sel;
   logic             reg_write;
   logic             mem_write;
   logic             mem_read;
   logic             oam_write;
   logic [1:0]       alu_src;
   logic [CNT_W-1:0] spr_word_idx;
   logic             ctrl_valid;

   modport master (
      output instr_valid, opcode, stall, flush,
      input  instr_ready, call, ret, branch,
      input  mem_to_reg, mem_src, sign_ext_sel,
      input  reg_write, mem_write, mem_read,
      input  oam_write, alu_src, spr_word_idx,
      input  ctrl_valid
   );

   modport slave (
      input  instr_valid, opcode, stall, flush,
      output instr_ready, call, ret, branch,
      output mem_to_reg, mem_src, sign_ext_sel,
      output reg_write, mem_write, mem_read,
      output oam_write, alu_src, spr_word_idx,
      output ctrl_valid
   );

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode decoder: maps an opcode to one control word and
// flags multi-beat sprite loads for the sequencer.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_word_t word,
   output logic       spr_load
);

   always_comb begin
      word     = CTRL_NOP;
      spr_load = 1'b0;
      unique case (1'b1)
         (opcode[5] == CLS_ALU): begin
            word.reg_write = 1'b1;
            if (!opcode[1] && opcode[0])
               word.alu_src = SRC_IMM;
            else if (opcode[1] && opcode[2])
               word.alu_src = SRC_SHAMT;
            else
               word.alu_src = SRC_RT;
         end
         (opcode[5:4] == CLS_CTRL): begin
            unique case (1'b1)
               !opcode[2]: begin
                  word.branch  = 1'b1;
                  word.alu_src = SRC_IMM;
               end
               (opcode[2] && !opcode[0]): begin
                  word.call      = 1'b1;
                  word.reg_write = 1'b1;
                  word.mem_write = 1'b1;
               end
               (opcode[2] && opcode[0]): begin
                  word.ret        = 1'b1;
                  word.reg_write  = 1'b1;
                  word.mem_read   = 1'b1;
                  word.mem_to_reg = 1'b1;
                  word.mem_src    = 1'b1;
               end
            endcase
         end
         (opcode[5:3] == CLS_MEM): begin
            word.alu_src      = SRC_IMM;
            word.sign_ext_sel = 1'b1;
            if (!opcode[2]) begin
               word.mem_read   = 1'b1;
               word.mem_to_reg = 1'b1;
               word.reg_write  = 1'b1;
            end else begin
               word.mem_write = 1'b1;
               word.mem_src   = 1'b1;
            end
         end
         (opcode[5:3] == CLS_SPR): begin
            word.oam_write = 1'b1;
            if (opcode[3:0] == SPR_STORE) begin
               word.alu_src = SRC_RT;
            end else begin
               word.mem_read = 1'b1;
               word.mem_src  = 1'b1;
               word.alu_src  = SRC_SPR;
               spr_load      = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Registers the decoded control word and replays sprite loads as a
// burst of OAM beats, with stall/flush pipeline control.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int SPR_WORDS = 4,
   parameter int CNT_W     = 4
) (
   input logic                clk,
   input logic                rst,
   control_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SPR_WORDS - 1);
   localparam bit               MULTI = (SPR_WORDS > 1);

   state_t           state;
   ctrl_word_t       word_q;
   ctrl_word_t       dec_word;
   logic             dec_load;
   logic             valid_q;
   logic             last_beat;
   logic             ready;
   logic [CNT_W-1:0] idx_q;

   control_decode u_dec (
      .opcode   (bus.opcode),
      .word     (dec_word),
      .spr_load (dec_load)
   );

   // Final burst beat frees the slot so the next opcode issues bubble-free
   assign last_beat = (state == IDLE) || (idx_q == LAST);
   assign ready     = !rst && !bus.stall && !bus.flush && last_beat;

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         state   <= IDLE;
         word_q  <= CTRL_NOP;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else if (!bus.stall) begin
         if (!last_beat) begin
            idx_q <= idx_q + CNT_W'(1);
         end else if (bus.instr_valid) begin
            word_q  <= dec_word;
            valid_q <= 1'b1;
            idx_q   <= '0;
            state   <= (dec_load && MULTI) ? BURST : IDLE;
         end else begin
            word_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            idx_q   <= '0;
            state   <= IDLE;
         end
      end
   end

   assign bus.instr_ready  = ready;
   assign bus.ctrl_valid   = valid_q;
   assign bus.spr_word_idx = idx_q;
   assign bus.call         = word_q.call;
   assign bus.ret          = word_q.ret;
   assign bus.branch       = word_q.branch;
   assign bus.mem_to_reg   = word_q.mem_to_reg;
   assign bus.mem_src      = word_q.mem_src;
   assign bus.sign_ext_sel = word_q.sign_ext_sel;
   assign bus.reg_write    = word_q.reg_write;
   assign bus.mem_write    = word_q.mem_write;
   assign bus.mem_read     = word_q.mem_read;
   assign bus.oam_write    = word_q.oam_write;
   assign bus.alu_src      = word_q.alu_src;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed vectors push expected
// per-cycle responses, a negedge monitor pops and compares them.
module tb_control_sequencer;

   localparam logic [11:0] CALL = 12'h800;
   localparam logic [11:0] RET  = 12'h400;
   localparam logic [11:0] BR   = 12'h200;
   localparam logic [11:0] M2R  = 12'h100;
   localparam logic [11:0] MSRC = 12'h080;
   localparam logic [11:0] SEXT = 12'h040;
   localparam logic [11:0] RW   = 12'h020;
   localparam logic [11:0] MW   = 12'h010;
   localparam logic [11:0] MR   = 12'h008;
   localparam logic [11:0] OAM  = 12'h004;
   localparam logic [11:0] IMM  = 12'h001;
   localparam logic [11:0] SHM  = 12'h002;
   localparam logic [11:0] SPR  = 12'h003;

   localparam logic [11:0] W_ADDI = RW | IMM;
   localparam logic [11:0] W_SHF  = RW | SHM;
   localparam logic [11:0] W_ALUR = RW;
   localparam logic [11:0] W_CALL = CALL | RW | MW;
   localparam logic [11:0] W_RET  = RET | RW | MR | M2R | MSRC;
   localparam logic [11:0] W_BEQ  = BR | IMM;
   localparam logic [11:0] W_SW   = MW | MSRC | SEXT | IMM;
   localparam logic [11:0] W_LW   = MR | M2R | RW | SEXT | IMM;
   localparam logic [11:0] W_SST  = OAM;
   localparam logic [11:0] W_SLD  = MR | OAM | MSRC | SPR;

   localparam logic [5:0] ADDI  = 6'b100001;
   localparam logic [5:0] SHF   = 6'b100110;
   localparam logic [5:0] ALUR  = 6'b100000;
   localparam logic [5:0] CALLO = 6'b000100;
   localparam logic [5:0] RETO  = 6'b000101;
   localparam logic [5:0] BEQ   = 6'b000000;
   localparam logic [5:0] SWO   = 6'b010100;
   localparam logic [5:0] LWO   = 6'b010000;
   localparam logic [5:0] SST   = 6'b011111;
   localparam logic [5:0] SLD   = 6'b011000;

   typedef struct {
      int          id;
      logic        rdy;
      logic        vld;
      logic [11:0] w;
      logic [3:0]  idx;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n_step;
   exp_t q[$];

   control_sequencer_if #(.CNT_W(4)) bus ();

   control_sequencer #(
      .SPR_WORDS (4),
      .CNT_W     (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id,
                      input logic [11:0] act,
                      input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s got %0h expected %0h",
                  id, nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [11:0] w;
         e = q.pop_front();
         w = {bus.call, bus.ret, bus.branch, bus.mem_to_reg,
              bus.mem_src, bus.sign_ext_sel, bus.reg_write,
              bus.mem_write, bus.mem_read, bus.oam_write,
              bus.alu_src};
         chk("ready", e.id, {11'd0, bus.instr_ready}, {11'd0, e.rdy});
         chk("valid", e.id, {11'd0, bus.ctrl_valid}, {11'd0, e.vld});
         chk("word", e.id, w, e.w);
         chk("idx", e.id, {8'd0, bus.spr_word_idx}, {8'd0, e.idx});
      end
   end

   task automatic step(input logic r, input logic iv,
                       input logic [5:0] op,
                       input logic st, input logic fl,
                       input logic e_rdy, input logic e_vld,
                       input logic [11:0] e_w,
                       input logic [3:0] e_idx);
      exp_t e;
      @(posedge clk);
      #1;
      n_step++;
      rst             = r;
      bus.instr_valid = iv;
      bus.opcode      = op;
      bus.stall       = st;
      bus.flush       = fl;
      e.id  = n_step;
      e.rdy = e_rdy;
      e.vld = e_vld;
      e.w   = e_w;
      e.idx = e_idx;
      q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      n_step = 0;
      rst             = 1'b1;
      bus.instr_valid = 1'b1;
      bus.opcode      = ADDI;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      // reset held two cycles with a live opcode
      step(1, 1, ADDI,  0, 0, 0, 0, 12'h0,  0);
      step(0, 1, ADDI,  0, 0, 1, 0, 12'h0,  0);
      step(0, 0, ADDI,  0, 0, 1, 1, W_ADDI, 0);
      // one opcode of each class, back to back
      step(0, 1, SHF,   0, 0, 1, 0, 12'h0,  0);
      step(0, 1, ALUR,  0, 0, 1, 1, W_SHF,  0);
      step(0, 1, CALLO, 0, 0, 1, 1, W_ALUR, 0);
      step(0, 1, RETO,  0, 0, 1, 1, W_CALL, 0);
      step(0, 1, BEQ,   0, 0, 1, 1, W_RET,  0);
      step(0, 1, SWO,   0, 0, 1, 1, W_BEQ,  0);
      step(0, 1, LWO,   0, 0, 1, 1, W_SW,   0);
      step(0, 1, SST,   0, 0, 1, 1, W_LW,   0);
      step(0, 1, SLD,   0, 0, 1, 1, W_SST,  0);
      // burst; held ADDI only issues on the final beat
      step(0, 1, ADDI,  0, 0, 0, 1, W_SLD,  0);
      step(0, 1, ADDI,  0, 0, 0, 1, W_SLD,  1);
      step(0, 1, ADDI,  0, 0, 0, 1, W_SLD,  2);
      step(0, 1, ADDI,  0, 0, 1, 1, W_SLD,  3);
      step(0, 0, ADDI,  0, 0, 1, 1, W_ADDI, 0);
      // burst stalled at beat 1 for three cycles
      step(0, 1, SLD,   0, 0, 1, 0, 12'h0,  0);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  0);
      step(0, 0, SLD,   1, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   1, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   1, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  2);
      step(0, 0, SLD,   0, 0, 1, 1, W_SLD,  3);
      // flush at beat 2, then LW
      step(0, 1, SLD,   0, 0, 1, 0, 12'h0,  0);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  0);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   0, 1, 0, 1, W_SLD,  2);
      step(0, 1, LWO,   0, 0, 1, 0, 12'h0,  0);
      // flush and stall together block acceptance
      step(0, 1, SHF,   0, 0, 1, 1, W_LW,   0);
      step(0, 1, ADDI,  1, 1, 0, 1, W_SHF,  0);
      step(0, 0, ADDI,  0, 0, 1, 0, 12'h0,  0);
      step(0, 0, ADDI,  0, 0, 1, 0, 12'h0,  0);
      // reset mid-burst
      step(0, 1, SLD,   0, 0, 1, 0, 12'h0,  0);
      step(0, 0, SLD,   0, 0, 0, 1, W_SLD,  0);
      step(1, 0, SLD,   0, 0, 0, 1, W_SLD,  1);
      step(0, 0, SLD,   0, 0, 1, 0, 12'h0,  0);
      step(0, 0, SLD,   0, 0, 1, 0, 12'h0,  0);
      @(negedge clk);
      #1;
      chk("drain", n_step, 12'(q.size()), 12'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
